cp0_intc: RTL and testbench
===========================

Name: cp0_intc

Overview:
- Coprocessor-0 / interrupt controller that consumes the interval timer's IRQ and other device IRQs on HWInt[7:2].
- Holds SR, Cause, EPC and PRId, arbitrates interrupts against synchronous exceptions, and raises a single Req to the pipeline flush/redirect logic.
- Sits at the M stage of the pipelined MIPS core.
- Serviced by mfc0/mtc0/eret.

Parameters:
- PRID, 32'h2017_1227, read-only processor ID returned at register 15.
- EXC_INT, 5'd0, ExcCode recorded for an external interrupt.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset (one clock; reset is synchronous and active-high)
- A1  input  5  mfc0 read register number
- A2  input  5  mtc0 write register number
- DIn  input  32  mtc0 write data
- WE  input  1  mtc0 write enable
- PC  input  32  address of the M-stage instruction
- BDIn  input  1  M-stage instruction is in a branch delay slot
- ExcCodeIn  input  5  synchronous exception code, 0 = none
- HWInt  input  6  device IRQs [7:2]; bit 2 = timer0, bit 3 = timer1
- EXLClr  input  1  eret in M stage
- Req  output  1  take interrupt/exception this cycle (combinational)
- EPCOut  output  32  current EPC, for eret redirect
- DOut  output  32  mfc0 read data (combinational)

Behaviour:
- Register fields:
  - SR(12): IM[15:10], EXL[1], IE[0]; all other bits read as 0.
  - Cause(13): BD[31], IP[15:10], ExcCode[6:2]; all other bits read as 0.
  - EPC(14): 32-bit, bits [1:0] always 0.
  - PRId(15): PRID.
  - Any other A1 reads 0.
- Reset: SR=0, Cause=0, EPC=0, so Req=0, DOut=0 for A1∉{15}, EPCOut=0.
- Request logic, combinational:
  - IntReq = |(HWInt & SR.IM) & SR.IE & ~SR.EXL
  - ExcReq = (ExcCodeIn != 0) & ~SR.EXL
  - Req = IntReq | ExcReq
- Priority: interrupt beats exception. On IntReq, ExcCode records EXC_INT even if ExcCodeIn != 0.
- On the posedge with Req=1:
  - SR.EXL<=1
  - Cause.ExcCode<=IntReq?EXC_INT:ExcCodeIn
  - Cause.BD<=BDIn
  - EPC<=(BDIn ? PC-4 : PC) & ~3
  - Any mtc0 (WE) in the same cycle is discarded; the faulting instruction does not commit.
  - EXLClr in the same cycle is ignored (cannot legally coincide, since Req requires EXL=0).
- Cause.IP<=HWInt every cycle regardless of Req/WE; it is not writable by mtc0.
- mtc0 (WE=1, Req=0):
  - A2=12: IM, EXL, IE <= DIn fields.
  - A2=14: EPC<=DIn & ~3.
  - A2=13, 15 or other: no effect.
- EXLClr=1, Req=0: SR.EXL<=0 on the posedge.
  - If WE to SR is in the same cycle, the mtc0 value is applied first and EXLClr then forces EXL=0.
- Reads are not bypassed: an mfc0 in the same cycle as an mtc0 to the same register returns the old value. The hazard unit is responsible.
- Level-sensitive interrupts: a device IRQ held high re-triggers as soon as EXL clears. Clearing the source (e.g. rewriting the timer ctrl) is software's job.
- EPCOut = EPC register; it updates one cycle after Req.
- Reset mid-handler: everything returns to reset values, so EXL=0 and IE=0 and all interrupts are masked.

Decomposition:
- Shared package/header: CP0 register numbers (12–15), SR/Cause bit-field positions, ExcCode constants (Int=0, AdEL=4, AdES=5, RI=10, Ov=12).
- No sub-module needed. An optional cp0_req_arb (pure combinational IntReq/ExcReq/code select) may be split out if reused by the pipeline control.

Test Plan:
- Reset, then read A1=15 -> DOut=PRID; read A1=12,13,14 -> 0; Req=0.
- mtc0 SR=32'h0000_0401 (IM[10]=1, IE=1); HWInt=6'b000001 with PC=32'h0000_3010, BDIn=0 -> Req=1 that cycle. Next cycle: EPC=32'h3010, SR.EXL=1, Cause.ExcCode=0, Req=0 while HWInt stays high.
- EXL=0, IE=0; ExcCodeIn=5'd12, PC=32'h3024, BDIn=1 -> Req=1. Next cycle: EPC=32'h3020, Cause=32'h8000_0030 | IP.
- Simultaneous: SR=32'h0000_FC01, HWInt[2]=1, ExcCodeIn=4, WE=1 A2=14 DIn=32'h1234 -> ExcCode=0, EPC=PC (mtc0 dropped).
- During the handler, HWInt still asserted; EXLClr=1 -> EXL=0 next cycle, Req reasserts on the following cycle. Pulse reset with EXL=1 -> SR=0 and Req stays 0.
- mtc0 EPC DIn=32'h0000_3007 -> EPCOut=32'h0000_3004. mtc0 to A2=13 with DIn=32'hFFFF_FFFF -> Cause unchanged except IP tracking HWInt.

Source files
------------

// File: rtl/cp0_intc_pkg.sv
// cp0_intc_pkg: CP0 register numbers, SR/Cause field positions, ExcCodes and field packing helpers
package cp0_intc_pkg;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam int SR_IE        = 0;
    localparam int SR_EXL       = 1;
    localparam int SR_IM_LO     = 10;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_BD     = 31;

    localparam logic [31:0] PRID_DEFAULT = 32'h2017_1227;

    typedef enum logic [4:0] {
        EC_INT  = 5'd0,
        EC_ADEL = 5'd4,
        EC_ADES = 5'd5,
        EC_RI   = 5'd10,
        EC_OV   = 5'd12
    } exc_code_e;

    function automatic logic [31:0] sr_word(input logic [5:0] im, input logic exl, input logic ie);
        sr_word = (32'(im) << SR_IM_LO) | (32'(exl) << SR_EXL) | (32'(ie) << SR_IE);
    endfunction

    function automatic logic [31:0] cause_word(input logic bd, input logic [5:0] ip, input logic [4:0] exc);
        cause_word = (32'(bd) << CAUSE_BD) | (32'(ip) << CAUSE_IP_LO) | (32'(exc) << CAUSE_EXC_LO);
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] a);
        word_align = a & ~32'h3;
    endfunction

endpackage

// File: rtl/cp0_intc_if.sv
// cp0_intc_if: M-stage pipeline <-> CP0 signals (mfc0/mtc0/eret, exceptions, device IRQs, redirect)
interface cp0_intc_if;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        WE;
    logic [31:0] PC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        Req;
    logic [31:0] EPCOut;
    logic [31:0] DOut;

    modport master (
        output A1, A2, DIn, WE, PC, BDIn, ExcCodeIn, HWInt, EXLClr,
        input  Req, EPCOut, DOut
    );

    modport slave (
        input  A1, A2, DIn, WE, PC, BDIn, ExcCodeIn, HWInt, EXLClr,
        output Req, EPCOut, DOut
    );
endinterface

// File: rtl/cp0_intc.sv
// cp0_intc: SR/Cause/EPC/PRId with interrupt-over-exception arbitration and a single Req to the pipeline
module cp0_intc
    import cp0_intc_pkg::*;
#(
    parameter logic [31:0] PRID    = PRID_DEFAULT,
    parameter logic [4:0]  EXC_INT = EC_INT
) (
    input logic        clk,
    input logic        reset,
    cp0_intc_if.slave  bus
);

    logic [5:0]  im_q, im_d, ip_q;
    logic        exl_q, exl_d, ie_q, ie_d, bd_q, bd_d;
    logic [4:0]  exc_q, exc_d;
    logic [31:0] epc_q, epc_d;
    logic        int_req, exc_req, req, wr_sr, wr_epc;

    always_comb begin
        int_req = |(bus.HWInt & im_q) & ie_q & ~exl_q;
        exc_req = (bus.ExcCodeIn != 5'd0) & ~exl_q;
        req     = int_req | exc_req;
        wr_sr   = bus.WE & ~req & (bus.A2 == REG_SR);
        wr_epc  = bus.WE & ~req & (bus.A2 == REG_EPC);
        im_d    = wr_sr ? bus.DIn[SR_IM_LO +: 6] : im_q;
        ie_d    = wr_sr ? bus.DIn[SR_IE] : ie_q;
        // eret clears EXL after any same-cycle mtc0 to SR
        exl_d   = req | (~bus.EXLClr & (wr_sr ? bus.DIn[SR_EXL] : exl_q));
        bd_d    = req ? bus.BDIn : bd_q;
        exc_d   = req ? (int_req ? EXC_INT : bus.ExcCodeIn) : exc_q;
        epc_d   = req    ? word_align(bus.BDIn ? bus.PC - 32'd4 : bus.PC) :
                  wr_epc ? word_align(bus.DIn) : epc_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            im_q  <= '0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
            bd_q  <= 1'b0;
            exc_q <= '0;
            epc_q <= '0;
            ip_q  <= '0;
        end else begin
            im_q  <= im_d;
            exl_q <= exl_d;
            ie_q  <= ie_d;
            bd_q  <= bd_d;
            exc_q <= exc_d;
            epc_q <= epc_d;
            ip_q  <= bus.HWInt;
        end
    end

    assign bus.Req    = req;
    assign bus.EPCOut = epc_q;
    assign bus.DOut   = (bus.A1 == REG_SR)    ? sr_word(im_q, exl_q, ie_q) :
                        (bus.A1 == REG_CAUSE) ? cause_word(bd_q, ip_q, exc_q) :
                        (bus.A1 == REG_EPC)   ? epc_q :
                        (bus.A1 == REG_PRID)  ? PRID : 32'd0;

endmodule

// File: tb/tb_cp0_intc.sv
// tb_cp0_intc: register-file model of CP0 checked every cycle, plus directed literal expectations
module tb_cp0_intc;

    localparam logic [31:0] PRID = 32'h2017_1227;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    bit   chk_en = 1'b0;
    logic [31:0] rf [32];

    cp0_intc_if bus();

    cp0_intc dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic m_int();
        m_int = (((32'(bus.HWInt) << 10) & rf[12]) != 32'd0) && rf[12][0] && !rf[12][1];
    endfunction

    function automatic logic m_req();
        m_req = m_int() || (bus.ExcCodeIn != 5'd0 && !rf[12][1]);
    endfunction

    // Whole-word register model: SR keeps only its writable mask, Cause IP follows HWInt
    always @(posedge clk) begin
        logic take, intr;
        take = m_req();
        intr = m_int();
        if (reset) begin
            foreach (rf[i]) rf[i] = 32'd0;
            rf[15] = PRID;
            chk_en = 1'b1;
        end else begin
            if (take) begin
                rf[12] = rf[12] | 32'h2;
                rf[13] = (32'(bus.BDIn) << 31) | (32'(intr ? 5'd0 : bus.ExcCodeIn) << 2);
                rf[14] = (bus.BDIn ? bus.PC - 32'd4 : bus.PC) & ~32'h3;
            end else begin
                if (bus.WE && bus.A2 == 5'd12) rf[12] = bus.DIn & 32'h0000_FC03;
                if (bus.WE && bus.A2 == 5'd14) rf[14] = bus.DIn & ~32'h3;
                if (bus.EXLClr) rf[12] = rf[12] & ~32'h2;
            end
            rf[13] = (rf[13] & ~32'h0000_FC00) | (32'(bus.HWInt) << 10);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req", 32'(bus.Req), 32'(m_req()));
            chk("dout", bus.DOut, rf[bus.A1]);
            chk("epcout", bus.EPCOut, rf[14]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pin(input string n, input logic [4:0] a, input logic [31:0] e);
        bus.A1 = a;
        #1;
        chk(n, bus.DOut, e);
    endtask

    task automatic pinr(input string n, input logic e);
        #1;
        chk(n, 32'(bus.Req), 32'(e));
    endtask

    initial begin
        bus.A1 = 5'd0; bus.A2 = 5'd0; bus.DIn = 32'd0; bus.WE = 1'b0; bus.PC = 32'd0;
        bus.BDIn = 1'b0; bus.ExcCodeIn = 5'd0; bus.HWInt = 6'd0; bus.EXLClr = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        pin("prid", 5'd15, PRID);
        pin("sr_rst", 5'd12, 32'd0);
        pin("cause_rst", 5'd13, 32'd0);
        pin("epc_rst", 5'd14, 32'd0);
        pinr("req_rst", 1'b0);
        // interrupt taken
        bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0401;
        tick();
        bus.WE = 1'b0; bus.HWInt = 6'b000001; bus.PC = 32'h0000_3010;
        pinr("int_req", 1'b1);
        tick();
        pinr("req_held_by_exl", 1'b0);
        pin("epc_int", 5'd14, 32'h0000_3010);
        pin("sr_exl", 5'd12, 32'h0000_0403);
        pin("cause_int", 5'd13, 32'h0000_0400);
        chk("epcout_int", bus.EPCOut, 32'h0000_3010);
        // exception in a delay slot
        bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'd0;
        tick();
        bus.WE = 1'b0; bus.HWInt = 6'd0; bus.ExcCodeIn = 5'd12; bus.PC = 32'h0000_3024; bus.BDIn = 1'b1;
        pinr("exc_req", 1'b1);
        tick();
        bus.ExcCodeIn = 5'd0; bus.BDIn = 1'b0;
        pin("epc_bd", 5'd14, 32'h0000_3020);
        pin("cause_bd", 5'd13, 32'h8000_0030);
        pin("sr_exc", 5'd12, 32'h0000_0002);
        bus.ExcCodeIn = 5'd4;
        pinr("exc_masked_exl", 1'b0);
        bus.ExcCodeIn = 5'd0;
        // interrupt beats exception, mtc0 dropped
        bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_FC01;
        tick();
        bus.HWInt = 6'b000001; bus.ExcCodeIn = 5'd4; bus.A2 = 5'd14; bus.DIn = 32'h0000_1234; bus.PC = 32'h0000_3040;
        pinr("int_beats_exc", 1'b1);
        tick();
        bus.WE = 1'b0; bus.ExcCodeIn = 5'd0;
        pin("epc_drop", 5'd14, 32'h0000_3040);
        pin("cause_pri", 5'd13, 32'h0000_0400);
        pin("sr_fc03", 5'd12, 32'h0000_FC03);
        // eret with the IRQ still high re-triggers
        bus.EXLClr = 1'b1;
        pinr("req_in_handler", 1'b0);
        tick();
        bus.EXLClr = 1'b0; bus.PC = 32'h0000_3050;
        pin("sr_exl_clr", 5'd12, 32'h0000_FC01);
        pinr("req_retrigger", 1'b1);
        tick();
        pin("sr_retaken", 5'd12, 32'h0000_FC03);
        pin("epc_retaken", 5'd14, 32'h0000_3050);
        // reset mid-handler
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pin("sr_reset", 5'd12, 32'd0);
        pinr("req_after_reset", 1'b0);
        chk("epcout_reset", bus.EPCOut, 32'd0);
        pin("prid_reset", 5'd15, PRID);
        // mtc0 SR and eret together
        bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0403; bus.EXLClr = 1'b1;
        tick();
        bus.WE = 1'b0; bus.EXLClr = 1'b0; bus.HWInt = 6'd0;
        pin("sr_wr_then_clr", 5'd12, 32'h0000_0401);
        // EPC alignment, read-only Cause and PRId
        bus.WE = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'h0000_3007;
        tick();
        bus.WE = 1'b0;
        chk("epc_align", bus.EPCOut, 32'h0000_3004);
        bus.WE = 1'b1; bus.A2 = 5'd13; bus.DIn = 32'hFFFF_FFFF; bus.HWInt = 6'b101000;
        tick();
        bus.A2 = 5'd15; bus.DIn = 32'd0;
        pin("cause_ro", 5'd13, 32'h0000_A000);
        tick();
        bus.WE = 1'b0; bus.HWInt = 6'd0;
        pin("prid_ro", 5'd15, PRID);
        // delay-slot EPC wraps below address 0
        bus.ExcCodeIn = 5'd10; bus.PC = 32'd0; bus.BDIn = 1'b1;
        pinr("ri_req", 1'b1);
        tick();
        bus.ExcCodeIn = 5'd0; bus.BDIn = 1'b0;
        pin("epc_wrap", 5'd14, 32'hFFFF_FFFC);
        pin("cause_ri", 5'd13, 32'h8000_0028);
        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
